// File: rtl/neuron_seq_pkg.sv
// rtl/neuron_seq_pkg.sv - shared state encoding and default sizing for the neuron training sequencer
package neuron_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FWD,
    BWD,
    NEXT,
    DONE
  } seq_state_t;

  localparam int DEF_LAYERS = 3;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/neuron_train_sequencer_if.sv
// rtl/neuron_train_sequencer_if.sv - sample fetch handshake and per-layer strobe bundle
interface neuron_train_sequencer_if #(
  parameter int LAYERS = 3,
  parameter int CNT_W  = 16
);

  logic              sample_req;
  logic              sample_valid;
  logic [CNT_W-1:0]  sample_idx;
  logic [CNT_W-1:0]  epoch;
  logic [LAYERS-1:0] layer_valid;
  logic [LAYERS-1:0] layer_learn;

  modport master (
    output sample_req, sample_idx, epoch, layer_valid, layer_learn,
    input  sample_valid
  );

  modport slave (
    input  sample_req, sample_idx, epoch, layer_valid, layer_learn,
    output sample_valid
  );

endinterface

// File: rtl/seq_stage_timer.sv
// rtl/seq_stage_timer.sv - layer index k and settle counter s walked up or down the layer stack
module seq_stage_timer #(
  parameter int LAYERS = 3,
  parameter int SETTLE = 2,
  localparam int K_W = (LAYERS > 1) ? $clog2(LAYERS) : 1,
  localparam int S_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic [K_W-1:0] load_val_i,
  input  logic           dir_down_i,
  input  logic           en_i,
  output logic [K_W-1:0] k_o,
  output logic           strobe_o,
  output logic           last_slot_o,
  output logic           last_layer_o
);

  logic [K_W-1:0] k_q, k_d;
  logic [S_W-1:0] s_q, s_d;

  assign k_o          = k_q;
  assign strobe_o     = (s_q == '0);
  assign last_slot_o  = (s_q == S_W'(SETTLE));
  assign last_layer_o = dir_down_i ? (k_q == '0) : (k_q == K_W'(LAYERS - 1));

  // Load wins over stepping so a pass can be re-armed in the same cycle it finishes.
  always_comb begin
    k_d = k_q;
    s_d = s_q;
    if (load_i) begin
      k_d = load_val_i;
      s_d = '0;
    end else if (en_i) begin
      if (last_slot_o) begin
        s_d = '0;
        if (!last_layer_o) begin
          k_d = dir_down_i ? (k_q - K_W'(1)) : (k_q + K_W'(1));
        end
      end else begin
        s_d = s_q + S_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q <= '0;
      s_q <= '0;
    end else begin
      k_q <= k_d;
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/neuron_train_sequencer.sv
// rtl/neuron_train_sequencer.sv - fetch/forward/backward scheduler for a neuron layer stack
// Optional NEURON_SEQ_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module neuron_train_sequencer
  import neuron_seq_pkg::*;
#(
  parameter int LAYERS = DEF_LAYERS,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [CNT_W-1:0] num_epochs,
  input  logic             learn_en,
  neuron_train_sequencer_if.master seq_if,
  output logic             busy,
  output logic             done
`ifdef NEURON_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  localparam int K_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] samp_q, samp_d, epoch_q, epoch_d;
  logic [CNT_W-1:0] nsamp_q, nsamp_d, nepoch_q, nepoch_d;
  logic             learn_q, learn_d;

  logic             t_load, t_dir, t_en, t_strobe, t_last_slot, t_last_layer;
  logic [K_W-1:0]   t_load_val, t_k;
  logic [LAYERS-1:0] onehot;

  seq_stage_timer #(.LAYERS(LAYERS), .SETTLE(SETTLE)) u_timer (
    .clk_i        (clock),
    .rst_i        (reset),
    .load_i       (t_load),
    .load_val_i   (t_load_val),
    .dir_down_i   (t_dir),
    .en_i         (t_en),
    .k_o          (t_k),
    .strobe_o     (t_strobe),
    .last_slot_o  (t_last_slot),
    .last_layer_o (t_last_layer)
  );

  assign onehot            = LAYERS'(1) << t_k;
  assign busy              = (state_q != IDLE);
  assign seq_if.sample_idx = samp_q;
  assign seq_if.epoch      = epoch_q;

  always_comb begin
    state_d            = state_q;
    samp_d             = samp_q;
    epoch_d            = epoch_q;
    nsamp_d            = nsamp_q;
    nepoch_d           = nepoch_q;
    learn_d            = learn_q;
    t_load             = 1'b0;
    t_load_val         = '0;
    t_dir              = 1'b0;
    t_en               = 1'b0;
    seq_if.sample_req  = 1'b0;
    seq_if.layer_valid = '0;
    seq_if.layer_learn = '0;
    done               = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          nsamp_d  = num_samples;
          nepoch_d = num_epochs;
          learn_d  = learn_en;
          samp_d   = '0;
          epoch_d  = '0;
          state_d  = (num_samples == '0 || num_epochs == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        seq_if.sample_req = 1'b1;
        if (seq_if.sample_valid) begin
          t_load  = 1'b1;
          state_d = FWD;
        end
      end
      FWD: begin
        t_en = 1'b1;
        if (t_strobe) seq_if.layer_valid = onehot;
        if (t_last_slot && t_last_layer) begin
          if (learn_q) begin
            t_load     = 1'b1;
            t_load_val = K_W'(LAYERS - 1);
            state_d    = BWD;
          end else begin
            state_d = NEXT;
          end
        end
      end
      BWD: begin
        t_dir = 1'b1;
        t_en  = 1'b1;
        if (t_strobe) begin
          seq_if.layer_valid = onehot;
          seq_if.layer_learn = onehot;
        end
        if (t_last_slot && t_last_layer) state_d = NEXT;
      end
      NEXT: begin
        if (samp_q < nsamp_q - CNT_W'(1)) begin
          samp_d  = samp_q + CNT_W'(1);
          state_d = FETCH;
        end else begin
          samp_d = '0;
          if (epoch_q < nepoch_q - CNT_W'(1)) begin
            epoch_d = epoch_q + CNT_W'(1);
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = !abort;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides whatever the state decided, but is meaningless from IDLE.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      samp_d  = '0;
      epoch_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      samp_q   <= '0;
      epoch_q  <= '0;
      nsamp_q  <= '0;
      nepoch_q <= '0;
      learn_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      epoch_q  <= epoch_d;
      nsamp_q  <= nsamp_d;
      nepoch_q <= nepoch_d;
      learn_q  <= learn_d;
    end
  end

`ifdef NEURON_SEQ_PERF_EN
  logic [31:0] perf_q;

  assign perf_cycles = perf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_q <= '0;
    end else if (state_q == IDLE && start) begin
      perf_q <= '0;
    end else if (state_q != IDLE && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// tb/tb_neuron_train_sequencer.sv - cycle trace reference bench for neuron_train_sequencer
module tb_neuron_train_sequencer;

  localparam int L = 3;
  localparam int S = 2;

  logic        clock = 1'b0;
  logic        reset, start, abort, learn_en, busy, done;
  logic [15:0] num_samples, num_epochs;
`ifdef NEURON_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  neuron_train_sequencer_if #(.LAYERS(L), .CNT_W(16)) sif ();

  neuron_train_sequencer #(.LAYERS(L), .SETTLE(S), .CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .num_samples (num_samples),
    .num_epochs  (num_epochs),
    .learn_en    (learn_en),
    .seq_if      (sif.master),
    .busy        (busy),
    .done        (done)
`ifdef NEURON_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [40:0] exp_q[$];
  bit          sv_q[$];
  bit          junk_q[$];
  int          busy_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [40:0] pk(input logic b, input logic d, input logic r,
                                     input logic [L-1:0] lv, input logic [L-1:0] ll,
                                     input logic [15:0] i, input logic [15:0] e);
    return {b, d, r, lv, ll, i, e};
  endfunction

  function automatic logic [40:0] obs_now();
    return pk(busy, done, sif.sample_req, sif.layer_valid, sif.layer_learn, sif.sample_idx, sif.epoch);
  endfunction

  task automatic push(input logic [40:0] v, input bit sv, input bit junk);
    exp_q.push_back(v);
    sv_q.push_back(sv);
    junk_q.push_back(junk);
    if (v[40]) busy_n++;
  endtask

  // Expected per-cycle trace of a whole run, starting the cycle after start is taken.
  task automatic build(input int ns, input int ne, input bit le, input int first_d, input bit rnd_d);
    int d;
    logic [15:0] fe;
    exp_q.delete(); sv_q.delete(); junk_q.delete();
    busy_n = 0;
    fe = '0;
    if (ns != 0 && ne != 0) begin
      for (int e = 0; e < ne; e++) begin
        for (int i = 0; i < ns; i++) begin
          d = (e == 0 && i == 0) ? first_d : (rnd_d ? int'($urandom_range(0, 3)) : 0);
          for (int j = 0; j <= d; j++)
            push(pk(1, 0, 1, 0, 0, 16'(i), 16'(e)), j == d, 1);
          for (int k = 0; k < L; k++)
            for (int s = 0; s <= S; s++)
              push(pk(1, 0, 0, (s == 0) ? L'(1 << k) : '0, 0, 16'(i), 16'(e)), 1'($urandom), 1);
          if (le)
            for (int k = L - 1; k >= 0; k--)
              for (int s = 0; s <= S; s++)
                push(pk(1, 0, 0, (s == 0) ? L'(1 << k) : '0, (s == 0) ? L'(1 << k) : '0,
                        16'(i), 16'(e)), 1'($urandom), 1);
          push(pk(1, 0, 0, 0, 0, 16'(i), 16'(e)), 1'($urandom), 1);
        end
      end
      fe = 16'(ne - 1);
    end
    push(pk(1, 1, 0, 0, 0, 0, fe), 1'($urandom), 1);
    push(pk(0, 0, 0, 0, 0, 0, fe), 1'($urandom), 0);
    push(pk(0, 0, 0, 0, 0, 0, fe), 1'($urandom), 0);
  endtask

  task automatic run(input string tag, input int ns, input int ne, input bit le,
                     input int abort_at, input bit use_rst);
    @(posedge clock); #1;
    start = 1; num_samples = 16'(ns); num_epochs = 16'(ne); learn_en = le;
    @(posedge clock); #1;
    start = 0;
    for (int t = 0; t < exp_q.size(); t++) begin
      sif.sample_valid = sv_q[t];
      if (junk_q[t]) begin
        start = 1'($urandom); num_samples = 16'($urandom);
        num_epochs = 16'($urandom); learn_en = 1'($urandom);
      end
      if (t + 1 == abort_at) begin
        if (use_rst) reset = 1; else abort = 1;
      end
      @(negedge clock);
      chk(tag, 64'(obs_now()), 64'(exp_q[t]));
      @(posedge clock); #1;
      abort = 0; reset = 0; start = 0;
      if (t + 1 == abort_at) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clock);
          chk({tag, "_after"}, 64'(obs_now()), 64'(0));
          @(posedge clock); #1;
        end
        break;
      end
    end
`ifdef NEURON_SEQ_PERF_EN
    if (abort_at == 0) chk({tag, "_perf"}, 64'(perf_cycles), 64'(busy_n));
`endif
  endtask

  initial begin
    int ns, ne;
    bit le;
    reset = 1; start = 0; abort = 0; learn_en = 0;
    num_samples = 0; num_epochs = 0; sif.sample_valid = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset", 64'(obs_now()), 64'(0));
    @(posedge clock); #1;
    reset = 0;
    abort = 1;
    @(posedge clock); #1;
    abort = 0;
    @(negedge clock);
    chk("idle_abort", 64'(obs_now()), 64'(0));

    build(2, 1, 1, 0, 0); run("train_basic", 2, 1, 1, 0, 0);
    build(2, 1, 0, 0, 0); run("infer_basic", 2, 1, 0, 0, 0);
    build(3, 2, 1, 0, 0); run("epoch_wrap", 3, 2, 1, 0, 0);
    build(1, 1, 1, 5, 0); run("backpressure", 1, 1, 1, 0, 0);
    build(2, 1, 1, 0, 0); run("abort_bwd", 2, 1, 1, 34, 0);
    build(2, 1, 1, 0, 0); run("reset_bwd", 2, 1, 1, 34, 1);
    build(0, 5, 1, 0, 0); run("zero_cfg", 0, 5, 1, 0, 0);
    build(4, 0, 0, 0, 0); run("zero_epochs", 4, 0, 0, 0, 0);
    for (int r = 0; r < 15; r++) begin
      ns = int'($urandom_range(0, 3));
      ne = int'($urandom_range(0, 3));
      le = 1'($urandom);
      build(ns, ne, le, int'($urandom_range(0, 4)), 1);
      run("random", ns, ne, le, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
